// File: rtl/bcd2bin.sv
// ---------------------------------------------------------------------------
// bcd2bin : converts four BCD digits (thousands..units) into a 14-bit binary
// value using Horner accumulation, one digit per clock edge.
//
// Timeline for a request accepted on edge E0:
//   E0 : digits captured, digit-range check captured, busy rises
//   E1 : acc = d1
//   E2 : acc = acc*10 + d2
//   E3 : acc = acc*10 + d3
//   E4 : out = acc*10 + d4 (or 0 on a bad digit), err updated,
//        out_valid pulses for one cycle, busy falls
//   E5 : earliest edge at which the next request can be accepted
// ---------------------------------------------------------------------------
module bcd2bin (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  N1,
    input  logic [3:0]  N2,
    input  logic [3:0]  N3,
    input  logic [3:0]  N4,
    output logic        busy,
    output logic        out_valid,
    output logic [13:0] out,
    output logic        err
);

    // One idle state plus one state per digit being folded into the accumulator.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_D1   = 3'd1,
        ST_D2   = 3'd2,
        ST_D3   = 3'd3,
        ST_D4   = 3'd4
    } state_t;

    state_t      state_q,  state_d;
    logic [3:0]  dig1_q,   dig1_d;
    logic [3:0]  dig2_q,   dig2_d;
    logic [3:0]  dig3_q,   dig3_d;
    logic [3:0]  dig4_q,   dig4_d;
    logic        bad_q,    bad_d;
    logic [13:0] acc_q,    acc_d;
    logic [13:0] out_q,    out_d;
    logic        err_q,    err_d;
    logic        ovalid_q, ovalid_d;
    logic        busy_q,   busy_d;

    // A BCD digit is only legal in the range 0..9.
    function automatic logic digit_bad(input logic [3:0] d);
        digit_bad = (d > 4'd9);
    endfunction

    // One Horner step: shift the decimal value left one place and add a digit.
    // With legal digits the accumulator never exceeds 9999, so 14 bits suffice;
    // with an illegal digit the value may wrap, but it is discarded anyway.
    function automatic logic [13:0] horner_step(input logic [13:0] acc,
                                                input logic [3:0]  d);
        horner_step = (acc * 14'd10) + {10'd0, d};
    endfunction

    // State, captured operands, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dig1_q   <= 4'd0;
            dig2_q   <= 4'd0;
            dig3_q   <= 4'd0;
            dig4_q   <= 4'd0;
            bad_q    <= 1'b0;
            acc_q    <= 14'd0;
            out_q    <= 14'd0;
            err_q    <= 1'b0;
            ovalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dig1_q   <= dig1_d;
            dig2_q   <= dig2_d;
            dig3_q   <= dig3_d;
            dig4_q   <= dig4_d;
            bad_q    <= bad_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            err_q    <= err_d;
            ovalid_q <= ovalid_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: accept in idle, then fold in one digit per cycle.
    always_comb begin
        state_d  = state_q;
        dig1_d   = dig1_q;
        dig2_d   = dig2_q;
        dig3_d   = dig3_q;
        dig4_d   = dig4_q;
        bad_d    = bad_q;
        acc_d    = acc_q;
        out_d    = out_q;
        err_d    = err_q;
        ovalid_d = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                // Requests are only seen here, so in_valid while busy is dropped.
                if (in_valid) begin
                    dig1_d  = N1;
                    dig2_d  = N2;
                    dig3_d  = N3;
                    dig4_d  = N4;
                    bad_d   = digit_bad(N1) | digit_bad(N2) |
                              digit_bad(N3) | digit_bad(N4);
                    busy_d  = 1'b1;
                    state_d = ST_D1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_D1: begin
                acc_d   = {10'd0, dig1_q};
                state_d = ST_D2;
            end
            ST_D2: begin
                acc_d   = horner_step(acc_q, dig2_q);
                state_d = ST_D3;
            end
            ST_D3: begin
                acc_d   = horner_step(acc_q, dig3_q);
                state_d = ST_D4;
            end
            ST_D4: begin
                acc_d    = horner_step(acc_q, dig4_q);
                if (bad_q) begin
                    out_d = 14'd0;
                end else begin
                    out_d = horner_step(acc_q, dig4_q);
                end
                err_d    = bad_q;
                ovalid_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                busy_d   = 1'b0;
                ovalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        busy      = busy_q;
        out_valid = ovalid_q;
        out       = out_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_bcd2bin.sv
// ---------------------------------------------------------------------------
// Testbench for bcd2bin: directed scenarios plus random traffic, checked every
// cycle against a transaction-level reference (decimal arithmetic plus a
// remaining-cycles counter for each request in flight).
// ---------------------------------------------------------------------------
module tb_bcd2bin;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  N1, N2, N3, N4;
    logic        busy;
    logic        out_valid;
    logic [13:0] out;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    // Reference model state
    int          m_cnt;
    logic        m_busy;
    logic        m_ov;
    logic [13:0] m_out;
    logic        m_err;
    logic [13:0] m_pend_out;
    logic        m_pend_err;

    bcd2bin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .N1        (N1),
        .N2        (N2),
        .N3        (N3),
        .N4        (N4),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (out),
        .err       (err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a request is accepted when no conversion is pending; its
    // decimal value appears exactly four edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt      <= 0;
            m_busy     <= 1'b0;
            m_ov       <= 1'b0;
            m_out      <= 14'd0;
            m_err      <= 1'b0;
            m_pend_out <= 14'd0;
            m_pend_err <= 1'b0;
        end else begin
            m_ov <= 1'b0;
            if (m_cnt == 0) begin
                if (in_valid) begin
                    int bad_i;
                    int val_i;
                    bad_i = (N1 > 9 || N2 > 9 || N3 > 9 || N4 > 9) ? 1 : 0;
                    val_i = int'(N1) * 1000 + int'(N2) * 100 + int'(N3) * 10 + int'(N4);
                    m_cnt      <= 4;
                    m_busy     <= 1'b1;
                    m_pend_out <= (bad_i != 0) ? 14'd0 : 14'(val_i);
                    m_pend_err <= (bad_i != 0);
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_ov   <= 1'b1;
                    m_out  <= m_pend_out;
                    m_err  <= m_pend_err;
                end
            end
        end
    end

    // Compare every output against the reference mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check_val("mon_busy",      32'(busy),      32'(m_busy));
            check_val("mon_out_valid", 32'(out_valid), 32'(m_ov));
            check_val("mon_out",       32'(out),       32'(m_out));
            check_val("mon_err",       32'(err),       32'(m_err));
        end
    end

    // Wait (bounded) for an idle cycle, issue one request, check its timing
    // and the constant result expected for those digits.
    task automatic req(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d,
                       input logic [13:0] exp_out, input logic exp_err);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) check_val("idle_timeout", 32'(busy), 32'd0);
        in_valid = 1'b1;
        N1 = a; N2 = b; N3 = c; N4 = d;
        @(posedge clk);                        // E0
        @(negedge clk);
        in_valid = 1'b0;
        N1 = 4'd15; N2 = 4'd15; N3 = 4'd15; N4 = 4'd15;   // must not matter
        check_val("req_busy", 32'(busy), 32'd1);
        repeat (3) begin                       // after E1, E2, E3
            @(negedge clk);
            check_val("req_early_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);                        // after E4
        check_val("req_valid", 32'(out_valid), 32'd1);
        check_val("req_out",   32'(out),       32'(exp_out));
        check_val("req_err",   32'(err),       32'(exp_err));
        check_val("req_idle",  32'(busy),      32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        N1 = 4'd0; N2 = 4'd0; N3 = 4'd0; N4 = 4'd0;
        #2;
        check_val("rst_out",   32'(out),       32'd0);
        check_val("rst_err",   32'(err),       32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic conversion, then back-to-back requests
        req(4'd0, 4'd0, 4'd1, 4'd2, 14'd12,   1'b0);
        req(4'd5, 4'd4, 4'd3, 4'd2, 14'd5432, 1'b0);
        req(4'd9, 4'd9, 4'd9, 4'd9, 14'd9999, 1'b0);
        req(4'd3, 4'd5, 4'd7, 4'd9, 14'd3579, 1'b0);
        req(4'd1, 4'd0, 4'd4, 4'd0, 14'd1040, 1'b0);
        req(4'd0, 4'd0, 4'd0, 4'd0, 14'd0,    1'b0);
        req(4'd1, 4'd10, 4'd0, 4'd0, 14'd0,   1'b1);
        req(4'd2, 4'd0, 4'd0, 4'd1, 14'd2001, 1'b0);   // err must clear again

        // in_valid held high with digits changing every cycle
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            N1 = 4'($urandom_range(0, 9));
            N2 = 4'($urandom_range(0, 9));
            N3 = 4'($urandom_range(0, 9));
            N4 = 4'($urandom_range(0, 9));
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Reset two cycles into a conversion aborts it
        in_valid = 1'b1;
        N1 = 4'd5; N2 = 4'd5; N3 = 4'd5; N4 = 4'd5;
        @(posedge clk);                        // E0
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);                        // E1
        @(posedge clk);                        // E2
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_out",   32'(out),       32'd0);
        check_val("abort_err",   32'(err),       32'd0);
        check_val("abort_valid", 32'(out_valid), 32'd0);
        check_val("abort_busy",  32'(busy),      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("abort_no_valid", 32'(out_valid), 32'd0);
        end
        req(4'd9, 4'd9, 4'd9, 4'd9, 14'd9999, 1'b0);

        // Random traffic, including illegal digits and occasional resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 20) begin
                N1 = 4'($urandom_range(0, 15));
                N2 = 4'($urandom_range(0, 15));
                N3 = 4'($urandom_range(0, 15));
                N4 = 4'($urandom_range(0, 15));
            end else begin
                N1 = 4'($urandom_range(0, 9));
                N2 = 4'($urandom_range(0, 9));
                N3 = 4'($urandom_range(0, 9));
                N4 = 4'($urandom_range(0, 9));
            end
            rst_n = ($urandom_range(0, 99) >= 2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
